shift_normalizer: RTL

SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

---
 rtl/shift_normalizer_pkg.sv | 18 +
 rtl/shift_normalizer_norm_step.sv | 36 +++
 rtl/shift_normalizer.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_normalizer_pkg.sv
// Shared constants, FSM state type and mode encodings for the shift normalizer.
package shift_normalizer_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_LOGICAL = 1'b0;
  localparam logic MODE_ARITH   = 1'b1;

  localparam logic [2:0] LAST_STAGE = 3'd4;

endpackage

// File: rtl/shift_normalizer_norm_step.sv
// One binary-search normalization stage: test the top k (or k+1) bits and
// shift left by k when they carry no information.
module norm_step #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] k,
  input  logic               mode,
  output logic [WIDTH-1:0]   shifted,
  output logic               take
);
  import shift_normalizer_pkg::*;

  logic [WIDTH-1:0]   ones;
  logic [WIDTH-1:0]   mask_k;
  logic [WIDTH-1:0]   mask_k1;
  logic [WIDTH-1:0]   top_k1;
  logic [SHAMT_W-1:0] k1;

  always_comb begin
    ones    = '1;
    k1      = k + SHAMT_W'(1);
    mask_k  = ~(ones >> k);
    mask_k1 = ~(ones >> k1);
    top_k1  = value & mask_k1;
    // Arithmetic mode keeps the sign bit, so k+1 equal bits are needed to drop k.
    if (mode == MODE_ARITH) begin
      take = (top_k1 == '0) || (top_k1 == mask_k1);
    end else begin
      take = ((value & mask_k) == '0);
    end
    shifted = take ? (value << k) : value;
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: five binary-search stages recover the left shift
// that removes leading zeros (logical) or redundant sign bits (arithmetic).
module shift_normalizer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  // 'type' is a reserved word in SystemVerilog, so the mode input is type_sel.
  input  logic               type_sel,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out,
  output logic [SHAMT_W-1:0] shamt,
  output logic               zero
);
  import shift_normalizer_pkg::*;

  localparam logic [SHAMT_W-1:0] K0 = SHAMT_W'(WIDTH / 2);

  state_e             state_q, state_d;
  logic [2:0]         stage_q, stage_d;
  logic [WIDTH-1:0]   work_q,  work_d;
  logic               mode_q,  mode_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               zero_q,  zero_d;

  logic [SHAMT_W-1:0] step_k;
  logic [WIDTH-1:0]   step_shifted;
  logic               step_take;

  assign step_k = K0 >> stage_q;

  norm_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .value   (work_q),
    .k       (step_k),
    .mode    (mode_q),
    .shifted (step_shifted),
    .take    (step_take)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d  = a;
          mode_d  = type_sel;
          shamt_d = '0;
          zero_d  = (a == '0);
          stage_d = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // step_k is a single power of two, so OR-ing it sets shamt bit (4-stage).
        if (step_take) begin
          work_d  = step_shifted;
          shamt_d = shamt_q | step_k;
        end
        if (stage_q == LAST_STAGE) begin
          stage_d = '0;
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end
      default: begin
        stage_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      work_q  <= '0;
      mode_q  <= MODE_LOGICAL;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign out   = work_q;
  assign shamt = shamt_q;
  assign zero  = zero_q;

endmodule
